// File: rtl/butterfly_ram_engine.sv
// In-place butterfly engine over two dual-port RAM banks with a host preload/readback port.
// Two cycles per element (read, write); START/DONE handshake; host port only acts while idle.
module butterfly_ram_engine #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 9,
  parameter int SATURATE = 0
) (
  input  logic              CLOCK_I,
  input  logic              RESET_I,
  input  logic              START_I,
  input  logic [1:0]        MODE_I,
  input  logic [ADDR_W-1:0] COUNT_I,
  output logic              BUSY_O,
  output logic              DONE_O,
  output logic [ADDR_W-1:0] ELEM_CNT_O,
  input  logic              HOST_BANK_I,
  input  logic [ADDR_W-1:0] HOST_ADDR_I,
  input  logic              HOST_WE_I,
  input  logic [DATA_W-1:0] HOST_WDATA_I,
  output logic [DATA_W-1:0] HOST_RDATA_O
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] HALF = ADDR_W'(DEPTH / 2);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [1:0]        mode_q, mode_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              live_q, live_d;
  logic              host_bank_q, host_bank_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  logic [DATA_W-1:0] bank0 [DEPTH];
  logic [DATA_W-1:0] bank1 [DEPTH];
  logic [DATA_W-1:0] qa0_q, qb0_q, qa1_q, qb1_q;

  logic [ADDR_W-1:0] addr_a, addr_b;
  logic              we_eng, we_host, we_a0, we_a1;
  logic [DATA_W-1:0] wd_a0, wd_a1;
  logic [DATA_W-1:0] res_p0, res_p1, res_u0, res_u1;
  logic [DATA_W:0]   sum0, sum1, dif0, dif1;
  logic [DATA_W-1:0] host_mux;

  // Port A is shared between host (idle) and engine (busy); port B is engine-only.
  always_comb begin
    addr_a  = (state_q == S_IDLE) ? HOST_ADDR_I : i_q;
    addr_b  = i_q + HALF;
    we_eng  = (state_q == S_WRITE) && !RESET_I;
    we_host = (state_q == S_IDLE) && HOST_WE_I;
    we_a0   = we_eng || (we_host && !HOST_BANK_I);
    we_a1   = we_eng || (we_host && HOST_BANK_I);
    wd_a0   = we_eng ? res_p0 : HOST_WDATA_I;
    wd_a1   = we_eng ? res_p1 : HOST_WDATA_I;
  end

  always_ff @(posedge CLOCK_I) begin
    if (we_a0)  bank0[addr_a] <= wd_a0;
    if (we_eng) bank0[addr_b] <= res_u0;
    if (we_a1)  bank1[addr_a] <= wd_a1;
    if (we_eng) bank1[addr_b] <= res_u1;
    qa0_q <= bank0[addr_a];
    qb0_q <= bank0[addr_b];
    qa1_q <= bank1[addr_a];
    qb1_q <= bank1[addr_b];
  end

  always_comb begin
    sum0 = {1'b0, qa0_q} + {1'b0, qb1_q};
    sum1 = {1'b0, qa1_q} + {1'b0, qb0_q};
    dif0 = {1'b0, qa1_q} - {1'b0, qb0_q};
    dif1 = {1'b0, qa0_q} - {1'b0, qb1_q};
    res_p0 = sum0[DATA_W-1:0];
    res_p1 = sum1[DATA_W-1:0];
    res_u0 = dif0[DATA_W-1:0];
    res_u1 = dif1[DATA_W-1:0];
    case (mode_q)
      2'b01: begin
        res_p0 = qb1_q;
        res_p1 = qb0_q;
        res_u0 = qa1_q;
        res_u1 = qa0_q;
      end
      2'b10: begin
        res_p0 = sum0[DATA_W:1];
        res_p1 = sum1[DATA_W:1];
        res_u0 = dif0[DATA_W:1];
        res_u1 = dif1[DATA_W:1];
      end
      default: begin
        // Carry-out clamps sums high; borrow-out clamps differences to zero.
        if (SATURATE != 0) begin
          if (sum0[DATA_W]) res_p0 = '1;
          if (sum1[DATA_W]) res_p1 = '1;
          if (dif0[DATA_W]) res_u0 = '0;
          if (dif1[DATA_W]) res_u1 = '0;
        end
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    count_d     = count_q;
    mode_d      = mode_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    live_d      = (state_q == S_IDLE);
    host_bank_d = HOST_BANK_I;
    host_mux    = host_bank_q ? qa1_q : qa0_q;
    hold_d      = live_q ? host_mux : hold_q;
    case (state_q)
      S_IDLE: begin
        if (START_I) begin
          mode_d  = MODE_I;
          count_d = (COUNT_I > HALF) ? HALF : COUNT_I;
          i_d     = '0;
          busy_d  = 1'b1;
          if (count_d == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: state_d = S_WRITE;
      S_WRITE: begin
        if (i_q == count_q - ADDR_W'(1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          i_d     = i_q + ADDR_W'(1);
          state_d = S_READ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_I) begin
    if (RESET_I) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      count_q     <= '0;
      mode_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      live_q      <= 1'b0;
      host_bank_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      live_q      <= live_d;
      host_bank_q <= host_bank_d;
      hold_q      <= hold_d;
    end
  end

  // Host readback shows the port-A word while idle and freezes once the engine takes the port.
  assign HOST_RDATA_O = live_q ? host_mux : hold_q;
  assign BUSY_O       = busy_q;
  assign DONE_O       = done_q;
  assign ELEM_CNT_O   = i_q;

endmodule

// File: tb/tb_butterfly_ram_engine.sv
// Randomised bench for butterfly_ram_engine: a plain-SATURATE and a saturating instance share
// all inputs and are each compared against an array-based reference model of both banks.
module tb_butterfly_ram_engine;

  logic       CLOCK_I = 1'b0;
  logic       RESET_I = 1'b1;
  logic       START_I = 1'b0;
  logic [1:0] MODE_I = '0;
  logic [8:0] COUNT_I = '0;
  logic       HOST_BANK_I = 1'b0;
  logic [8:0] HOST_ADDR_I = '0;
  logic       HOST_WE_I = 1'b0;
  logic [7:0] HOST_WDATA_I = '0;

  logic       busy0, busy1, done0, done1;
  logic [8:0] elem0, elem1;
  logic [7:0] rdata0, rdata1;

  int checks = 0;
  int errors = 0;
  int mdl [2][2][512];

  always #5 CLOCK_I = ~CLOCK_I;

  butterfly_ram_engine #(.DATA_W(8), .ADDR_W(9), .SATURATE(0)) dut (
    .CLOCK_I(CLOCK_I), .RESET_I(RESET_I), .START_I(START_I), .MODE_I(MODE_I),
    .COUNT_I(COUNT_I), .BUSY_O(busy0), .DONE_O(done0), .ELEM_CNT_O(elem0),
    .HOST_BANK_I(HOST_BANK_I), .HOST_ADDR_I(HOST_ADDR_I), .HOST_WE_I(HOST_WE_I),
    .HOST_WDATA_I(HOST_WDATA_I), .HOST_RDATA_O(rdata0));

  butterfly_ram_engine #(.DATA_W(8), .ADDR_W(9), .SATURATE(1)) dut_sat (
    .CLOCK_I(CLOCK_I), .RESET_I(RESET_I), .START_I(START_I), .MODE_I(MODE_I),
    .COUNT_I(COUNT_I), .BUSY_O(busy1), .DONE_O(done1), .ELEM_CNT_O(elem1),
    .HOST_BANK_I(HOST_BANK_I), .HOST_ADDR_I(HOST_ADDR_I), .HOST_WE_I(HOST_WE_I),
    .HOST_WDATA_I(HOST_WDATA_I), .HOST_RDATA_O(rdata1));

  function automatic int f_sum(int a, int b, int mode, int sat);
    int s = a + b;
    if (mode == 2) return s / 2;
    if (sat != 0 && s > 255) return 255;
    return s % 256;
  endfunction

  function automatic int f_dif(int a, int b, int mode, int sat);
    int d = a - b;
    if (mode == 2) return ((d + 512) % 512) / 2;
    if (sat != 0 && d < 0) return 0;
    return (d + 256) % 256;
  endfunction

  task automatic apply_model(input int mode, input int count);
    int n = (count > 256) ? 256 : count;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < n; i++) begin
        int a0 = mdl[d][0][i];
        int b0 = mdl[d][0][i + 256];
        int a1 = mdl[d][1][i];
        int b1 = mdl[d][1][i + 256];
        if (mode == 1) begin
          mdl[d][0][i] = b1;
          mdl[d][1][i] = b0;
          mdl[d][0][i + 256] = a1;
          mdl[d][1][i + 256] = a0;
        end else begin
          mdl[d][0][i] = f_sum(a0, b1, mode, d);
          mdl[d][1][i] = f_sum(a1, b0, mode, d);
          mdl[d][0][i + 256] = f_dif(a1, b0, mode, d);
          mdl[d][1][i + 256] = f_dif(a0, b1, mode, d);
        end
      end
    end
  endtask

  task automatic host_write(input int b, input int a, input int v);
    HOST_BANK_I = b[0];
    HOST_ADDR_I = a[8:0];
    HOST_WDATA_I = v[7:0];
    HOST_WE_I = 1'b1;
    @(posedge CLOCK_I); #1;
    HOST_WE_I = 1'b0;
    mdl[0][b][a] = v % 256;
    mdl[1][b][a] = v % 256;
  endtask

  task automatic host_read(input int b, input int a, output logic [7:0] v0, output logic [7:0] v1);
    HOST_BANK_I = b[0];
    HOST_ADDR_I = a[8:0];
    @(posedge CLOCK_I); #1;
    v0 = rdata0;
    v1 = rdata1;
  endtask

  task automatic preload(input int pattern);
    for (int i = 0; i < 256; i++) begin
      if (pattern != 0) begin
        host_write(0, i, i % 256);
        host_write(0, i + 256, (2 * i) % 256);
        host_write(1, i, (3 * i) % 256);
        host_write(1, i + 256, (4 * i) % 256);
      end else begin
        host_write(0, i, $urandom_range(0, 255));
        host_write(0, i + 256, $urandom_range(0, 255));
        host_write(1, i, $urandom_range(0, 255));
        host_write(1, i + 256, $urandom_range(0, 255));
      end
    end
  endtask

  task automatic readback(input string name);
    int bad [2] = '{0, 0};
    int first_a [2] = '{0, 0};
    int first_b [2] = '{0, 0};
    logic [7:0] got [2] = '{8'h0, 8'h0};
    logic [7:0] v0, v1;
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < 512; a++) begin
        host_read(b, a, v0, v1);
        if (v0 !== 8'(mdl[0][b][a])) begin
          if (bad[0] == 0) begin first_a[0] = a; first_b[0] = b; got[0] = v0; end
          bad[0]++;
        end
        if (v1 !== 8'(mdl[1][b][a])) begin
          if (bad[1] == 0) begin first_a[1] = a; first_b[1] = b; got[1] = v1; end
          bad[1]++;
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (bad[d] !== 0) begin
        errors++;
        $display("FAIL %s ram dut%0d: %0d bad words, bank%0d[%0d] got %0d expected %0d",
                 name, d, bad[d], first_b[d], first_a[d], got[d],
                 mdl[d][first_b[d]][first_a[d]]);
      end
    end
  endtask

  // Starts an operation, returns how many rising edges from the accepting edge until DONE is seen.
  task automatic run_op(input int mode, input int count, output int n);
    START_I = 1'b1;
    MODE_I = mode[1:0];
    COUNT_I = count[8:0];
    @(posedge CLOCK_I); #1;
    START_I = 1'b0;
    n = 1;
    while (done0 !== 1'b1 && n < 2000) begin
      @(posedge CLOCK_I); #1;
      n++;
    end
    checks++;
    if (done1 !== done0) begin
      errors++;
      $display("FAIL done_sync: sat instance done=%b, plain done=%b", done1, done0);
    end
    @(posedge CLOCK_I); #1;
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL post_done: busy=%b done=%b, expected 0 0", busy0, done0);
    end
    apply_model(mode, count);
  endtask

  task automatic test_reset;
    RESET_I = 1'b1;
    repeat (3) @(posedge CLOCK_I);
    #1;
    checks++;
    if ({busy0, busy1, done0, done1} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: busy=%b%b done=%b%b expected all 0", busy0, busy1, done0, done1);
    end
    checks++;
    if (elem0 !== 9'd0 || elem1 !== 9'd0) begin
      errors++;
      $display("FAIL reset_elem: got %0d/%0d expected 0", elem0, elem1);
    end
    checks++;
    if (rdata0 !== 8'd0 || rdata1 !== 8'd0) begin
      errors++;
      $display("FAIL reset_rdata: got %0h/%0h expected 0", rdata0, rdata1);
    end
    RESET_I = 1'b0;
    @(posedge CLOCK_I); #1;
  endtask

  task automatic test_add_sub;
    int n;
    logic [7:0] v0, v1;
    preload(1);
    run_op(0, 256, n);
    checks++;
    if (n !== 513) begin
      errors++;
      $display("FAIL addsub_latency: done after %0d cycles expected 513", n);
    end
    host_read(0, 5, v0, v1);
    checks++;
    if (v0 !== 8'd25) begin errors++; $display("FAIL addsub_p0: got %0d expected 25", v0); end
    host_read(1, 5, v0, v1);
    checks++;
    if (v0 !== 8'd25) begin errors++; $display("FAIL addsub_p1: got %0d expected 25", v0); end
    host_read(0, 261, v0, v1);
    checks++;
    if (v0 !== 8'd5) begin errors++; $display("FAIL addsub_q0: got %0d expected 5", v0); end
    host_read(1, 261, v0, v1);
    checks++;
    if (v0 !== 8'hF1 || v1 !== 8'h00) begin
      errors++;
      $display("FAIL addsub_q1: got %0h/%0h expected f1/00", v0, v1);
    end
    readback("addsub");
  endtask

  task automatic test_swap;
    int n;
    int old0 [5];
    int old1 [5];
    logic [7:0] v0, v1;
    preload(0);
    for (int k = 0; k < 5; k++) begin
      old0[k] = mdl[0][0][k];
      old1[k] = mdl[0][1][256 + k];
    end
    run_op(1, 4, n);
    checks++;
    if (n !== 9) begin errors++; $display("FAIL swap_latency: got %0d expected 9", n); end
    for (int k = 0; k < 4; k++) begin
      host_read(0, k, v0, v1);
      checks++;
      if (v0 !== 8'(old1[k])) begin
        errors++;
        $display("FAIL swap_lo%0d: got %0d expected %0d", k, v0, old1[k]);
      end
      host_read(1, 256 + k, v0, v1);
      checks++;
      if (v0 !== 8'(old0[k])) begin
        errors++;
        $display("FAIL swap_hi%0d: got %0d expected %0d", k, v0, old0[k]);
      end
    end
    host_read(0, 4, v0, v1);
    checks++;
    if (v0 !== 8'(old0[4])) begin
      errors++;
      $display("FAIL swap_idx4: got %0d expected %0d", v0, old0[4]);
    end
    readback("swap");
  endtask

  task automatic test_saturate;
    int n;
    logic [7:0] v0, v1;
    host_write(0, 0, 200);
    host_write(0, 256, 20);
    host_write(1, 0, 10);
    host_write(1, 256, 100);
    run_op(0, 1, n);
    host_read(0, 0, v0, v1);
    checks++;
    if (v1 !== 8'd255 || v0 !== 8'd44) begin
      errors++;
      $display("FAIL sat_p0: got sat=%0d plain=%0d expected 255 44", v1, v0);
    end
    host_read(1, 256, v0, v1);
    checks++;
    if (v1 !== 8'd100) begin errors++; $display("FAIL sat_q1: got %0d expected 100", v1); end
    host_read(0, 256, v0, v1);
    checks++;
    if (v1 !== 8'd0 || v0 !== 8'd246) begin
      errors++;
      $display("FAIL sat_q0: got sat=%0d plain=%0d expected 0 246", v1, v0);
    end
    host_write(0, 0, 200);
    host_write(1, 256, 100);
    run_op(2, 1, n);
    host_read(0, 0, v0, v1);
    checks++;
    if (v0 !== 8'd150 || v1 !== 8'd150) begin
      errors++;
      $display("FAIL sat_halved: got %0d/%0d expected 150", v0, v1);
    end
    readback("saturate");
  endtask

  task automatic test_boundaries;
    int n;
    run_op(0, 0, n);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL count0_latency: got %0d expected 1", n); end
    readback("count0");
    run_op(int'($urandom_range(0, 3)), 300, n);
    checks++;
    if (n !== 513) begin errors++; $display("FAIL count300_latency: got %0d expected 513", n); end
    readback("count300");
  endtask

  task automatic test_ignored;
    int n;
    logic [7:0] cur;
    cur = 8'(mdl[0][0][100]);
    START_I = 1'b1;
    MODE_I = 2'd0;
    COUNT_I = 9'd20;
    @(posedge CLOCK_I); #1;
    START_I = 1'b0;
    n = 1;
    while (done0 !== 1'b1 && n < 2000) begin
      if (n == 7) begin
        START_I = 1'b1;
        COUNT_I = 9'd3;
        HOST_WE_I = 1'b1;
        HOST_BANK_I = 1'b0;
        HOST_ADDR_I = 9'd100;
        HOST_WDATA_I = ~cur;
      end
      if (n == 9) begin
        START_I = 1'b0;
        HOST_WE_I = 1'b0;
      end
      @(posedge CLOCK_I); #1;
      n++;
    end
    checks++;
    if (n !== 41) begin errors++; $display("FAIL busy_ignore_latency: got %0d expected 41", n); end
    START_I = 1'b1;
    @(posedge CLOCK_I); #1;
    START_I = 1'b0;
    @(posedge CLOCK_I); #1;
    checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL start_on_done: busy=%b%b expected 00", busy0, busy1);
    end
    apply_model(0, 20);
    readback("ignored");
  endtask

  task automatic test_reset_mid;
    int n;
    int k = 0;
    preload(0);
    START_I = 1'b1;
    MODE_I = 2'd0;
    COUNT_I = 9'd256;
    @(posedge CLOCK_I); #1;
    START_I = 1'b0;
    while (elem0 !== 9'd10 && k < 100) begin
      @(posedge CLOCK_I); #1;
      k++;
    end
    checks++;
    if (k >= 100) begin errors++; $display("FAIL reach_elem10: elem=%0d expected 10", elem0); end
    RESET_I = 1'b1;
    @(posedge CLOCK_I); #1;
    checks++;
    if ({busy0, busy1, done0, done1} !== 4'b0000 || elem0 !== 9'd0 || elem1 !== 9'd0) begin
      errors++;
      $display("FAIL midreset_state: busy=%b%b done=%b%b elem=%0d/%0d expected zeros",
               busy0, busy1, done0, done1, elem0, elem1);
    end
    RESET_I = 1'b0;
    @(posedge CLOCK_I); #1;
    apply_model(0, 10);
    readback("midreset");
    run_op(int'($urandom_range(0, 3)), 8, n);
    checks++;
    if (n !== 17) begin errors++; $display("FAIL restart_latency: got %0d expected 17", n); end
    readback("restart");
  endtask

  task automatic test_random;
    int n;
    for (int it = 0; it < 3; it++) begin
      int cnt = $urandom_range(1, 40);
      run_op(int'($urandom_range(0, 3)), cnt, n);
      checks++;
      if (n !== 2 * cnt + 1) begin
        errors++;
        $display("FAIL random_latency%0d: got %0d expected %0d", it, n, 2 * cnt + 1);
      end
      readback("random");
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_swap();
    test_saturate();
    test_boundaries();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
